// File: rtl/instruction_encoder_pkg.sv
// instruction_encoder_pkg: RV32 format codes and bundle legality rule shared by the encoder
package instruction_encoder_pkg;
    typedef enum logic [2:0] {
        R_TYPE = 3'd0,
        I_TYPE = 3'd1,
        S_TYPE = 3'd2,
        B_TYPE = 3'd3,
        U_TYPE = 3'd4,
        J_TYPE = 3'd5
    } fmt_t;
    // B/J immediates are byte offsets that must be halfword aligned
    function automatic logic fmt_legal(input logic [2:0] t, input logic imm0);
        return (t <= J_TYPE) && !((t == B_TYPE || t == J_TYPE) && imm0);
    endfunction
endpackage

// File: rtl/instruction_encoder_fifo.sv
// instruction_encoder_fifo: synchronous FIFO with combinational head, zero while empty
//   clk, reset (async active-low); push/din write; pop removes head; full, empty, head status
module instruction_encoder_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    // extra pointer MSB distinguishes full from empty when the index bits match
    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = wr_ptr == rd_ptr;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder: packs decoded RV32 fields into instruction words, buffered in an output FIFO
//   clk, reset (async active-low); in_valid/in_ready + in_* fields: bundle input
//   out_valid/out_ready/out_instruction: word output; err_illegal: rejected-bundle pulse
//   encoded_count: legal words written since reset
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_type,
    input  logic [6:0]             in_opcode,
    input  logic [2:0]             in_funct3,
    input  logic [6:0]             in_funct7,
    input  logic [4:0]             in_rd,
    input  logic [4:0]             in_rs1,
    input  logic [4:0]             in_rs2,
    input  logic [31:0]            in_imm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_instruction,
    output logic                   err_illegal,
    output logic [COUNT_WIDTH-1:0] encoded_count
);
    logic [31:0] word;
    logic legal, accept, full, empty;
    always_comb
        word = (in_type == R_TYPE) ? {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode}
             : (in_type == I_TYPE) ? {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode}
             : (in_type == S_TYPE) ? {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode}
             : (in_type == B_TYPE) ? {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], in_opcode}
             : (in_type == U_TYPE) ? {in_imm[31:12], in_rd, in_opcode}
             : {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
    assign legal = fmt_legal(in_type, in_imm[0]);
    assign in_ready = !full;
    assign accept = in_valid && in_ready;
    assign out_valid = !empty;
    // illegal bundles complete the handshake but never reach the FIFO
    instruction_encoder_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept && legal),
        .pop   (out_ready),
        .din   (word),
        .full  (full),
        .empty (empty),
        .head  (out_instruction)
    );
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            err_illegal <= 1'b0;
            encoded_count <= '0;
        end else begin
            err_illegal <= accept && !legal;
            if (accept && legal) encoded_count <= encoded_count + COUNT_WIDTH'(1);
        end
endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: scoreboard bench with a field-arithmetic reference encoder
module tb_instruction_encoder;
    import instruction_encoder_pkg::*;
    localparam int DEPTH = 4;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_type = '0;
    logic [6:0]  in_opcode = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instruction;
    logic        err_illegal;
    logic [15:0] encoded_count;
    int          errors = 0;
    int          checks = 0;
    int          ready_mode = 0;
    logic [15:0] cnt_model = '0;
    logic [31:0] exp_q[$];

    instruction_encoder #(.DEPTH(DEPTH), .COUNT_WIDTH(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_type         (in_type),
        .in_opcode       (in_opcode),
        .in_funct3       (in_funct3),
        .in_funct7       (in_funct7),
        .in_rd           (in_rd),
        .in_rs1          (in_rs1),
        .in_rs2          (in_rs2),
        .in_imm          (in_imm),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .err_illegal     (err_illegal),
        .encoded_count   (encoded_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] t, input logic [6:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [31:0] imm);
        bit [31:0] o, d, f, s1, s2, f7w, base;
        o = 32'(op); d = 32'(rd); f = 32'(f3); s1 = 32'(rs1); s2 = 32'(rs2); f7w = 32'(f7);
        base = o | (f << 12) | (s1 << 15);
        case (t)
            R_TYPE:  return base | (d << 7) | (s2 << 20) | (f7w << 25);
            I_TYPE:  return base | (d << 7) | ((imm & 32'hfff) << 20);
            S_TYPE:  return base | ((imm & 31) << 7) | (s2 << 20) | (((imm >> 5) & 127) << 25);
            B_TYPE:  return base | (((imm >> 11) & 1) << 7) | (((imm >> 1) & 15) << 8) | (s2 << 20)
                            | (((imm >> 5) & 63) << 25) | (((imm >> 12) & 1) << 31);
            U_TYPE:  return o | (d << 7) | (imm & 32'hfffff000);
            default: return o | (d << 7) | (((imm >> 12) & 255) << 12) | (((imm >> 11) & 1) << 20)
                            | (((imm >> 1) & 1023) << 21) | (((imm >> 20) & 1) << 31);
        endcase
    endfunction

    function automatic logic legal_model(input logic [2:0] t, input logic [31:0] imm);
        return t < 3'd6 && !((t == B_TYPE || t == J_TYPE) && imm[0]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [2:0] t, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic [31:0] exp_word, input logic exp_legal);
        int n = 0;
        in_type = t; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        if (exp_legal) begin
            exp_q.push_back(exp_word);
            cnt_model++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("err_illegal", 32'(err_illegal), 32'(!exp_legal));
        chk("encoded_count", 32'(encoded_count), 32'(cnt_model));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    initial forever begin
        @(negedge clk);
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %h expected none", out_instruction);
            end else
                chk("out_word", out_instruction, exp_q.pop_front());
        end
    end

    initial forever begin
        @(posedge clk);
        #1 out_ready = (ready_mode == 2) ? ($urandom_range(0, 3) != 0) : (ready_mode == 1);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  t, f3;
        logic [6:0]  op, f7;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm, first;
        int          r;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instruction", out_instruction, 32'd0);
        chk("rst_err_illegal", 32'(err_illegal), 32'd0);
        chk("rst_count", 32'(encoded_count), 32'd0);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        send(I_TYPE, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b1);
        chk("lat_out_valid", 32'(out_valid), 32'd1);
        chk("lat_out_instruction", out_instruction, 32'h00500093);
        ready_mode = 1;
        send(R_TYPE, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b1);
        send(S_TYPE, 7'b0100011, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020A423, 1'b1);
        send(B_TYPE, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd8, 32'h00000463, 1'b1);
        send(U_TYPE, 7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b1);
        send(J_TYPE, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h800, 32'h001000EF, 1'b1);
        drain();

        send(B_TYPE, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3, 32'd0, 1'b0);
        chk("illegal_b_no_valid", 32'(out_valid), 32'd0);
        send(3'b111, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'd0, 1'b0);
        chk("illegal_type_no_valid", 32'(out_valid), 32'd0);
        chk("illegal_count", 32'(encoded_count), 32'd6);

        ready_mode = 0;
        @(negedge clk);
        @(negedge clk);
        first = model(I_TYPE, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
        for (int i = 0; i < DEPTH; i++)
            send(I_TYPE, 7'b0010011, 3'd0, 7'd0, 5'(i + 1), 5'd0, 5'd0, 32'(i),
                 model(I_TYPE, 7'b0010011, 3'd0, 7'd0, 5'(i + 1), 5'd0, 5'd0, 32'(i)), 1'b1);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_head", out_instruction, first);
        @(negedge clk);
        chk("full_head_stable", out_instruction, first);
        ready_mode = 1;
        send(I_TYPE, 7'b0010011, 3'd0, 7'd0, 5'd9, 5'd0, 5'd0, 32'd9,
             model(I_TYPE, 7'b0010011, 3'd0, 7'd0, 5'd9, 5'd0, 5'd0, 32'd9), 1'b1);
        drain();
        chk("drained_in_ready", 32'(in_ready), 32'd1);

        ready_mode = 2;
        for (int k = 0; k < 1000; k++) begin
            r = $urandom_range(0, 19);
            t = (r < 18) ? 3'(r % 6) : 3'(6 + r % 2);
            imm = $urandom;
            if ((t == B_TYPE || t == J_TYPE) && $urandom_range(0, 9) != 0) imm[0] = 1'b0;
            op = 7'($urandom); f3 = 3'($urandom); f7 = 7'($urandom);
            rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
            send(t, op, f3, f7, rd, rs1, rs2, imm, model(t, op, f3, f7, rd, rs1, rs2, imm), legal_model(t, imm));
        end
        drain();
        chk("random_count", 32'(encoded_count), 32'(cnt_model));

        ready_mode = 0;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            imm = $urandom;
            send(U_TYPE, 7'b0110111, 3'd0, 7'd0, 5'(i), 5'd0, 5'd0, imm,
                 model(U_TYPE, 7'b0110111, 3'd0, 7'd0, 5'(i), 5'd0, 5'd0, imm), 1'b1);
        end
        #2 reset = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_instruction", out_instruction, 32'd0);
        chk("midrst_count", 32'(encoded_count), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        cnt_model = '0;
        @(negedge clk) reset = 1'b1;
        ready_mode = 1;
        send(I_TYPE, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b1);
        drain();
        chk("post_rst_count", 32'(encoded_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
